// File: rtl/port_ingress_fifo.sv
// Ingress FIFO for a switch port: filters bad packets (no target, unknown port, loopback)
// and stores the rest in a first-word-fall-through queue with a saturating drop counter.
module port_ingress_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [ADDR_W-1:0]            source_in,
    input  logic [ADDR_W-1:0]            target_in,
    input  logic [DATA_W-1:0]            data_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [ADDR_W-1:0]            source_out,
    output logic [ADDR_W-1:0]            target_out,
    output logic [DATA_W-1:0]            data_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0] src_mem_q  [DEPTH];
    logic [ADDR_W-1:0] tgt_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [ADDR_W-1:0] valid_ports;
    logic              accept;
    logic              pop;
    logic              drop;
    logic              store;

    always_comb begin
        for (int i = 0; i < ADDR_W; i++) begin
            valid_ports[i] = (i < NUM_PORTS);
        end
    end

    // ready_in looks only at the stored level, so a full FIFO refuses even while popping.
    always_comb begin
        ready_in   = (level_q != LVL_W'(DEPTH));
        valid_out  = (level_q != '0);
        accept     = valid_in && ready_in;
        pop        = valid_out && ready_out;
        drop       = (target_in == '0) || (|(target_in & ~valid_ports)) || (|(target_in & source_in));
        store      = accept && !drop;

        wr_ptr_d   = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d    = level_q;
        case ({store, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        drop_cnt_d = (accept && drop) ? sat_inc(drop_cnt_q) : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is never cleared; the zeroing mux below hides stale entries.
    always_ff @(posedge clk) begin
        if (store && !rst) begin
            src_mem_q[wr_ptr_q]  <= source_in;
            tgt_mem_q[wr_ptr_q]  <= target_in;
            data_mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_comb begin
        source_out = valid_out ? src_mem_q[rd_ptr_q]  : '0;
        target_out = valid_out ? tgt_mem_q[rd_ptr_q]  : '0;
        data_out   = valid_out ? data_mem_q[rd_ptr_q] : '0;
    end

    assign level    = level_q;
    assign drop_cnt = drop_cnt_q;

endmodule
